// File: rtl/pipe_stage_reg_if.sv
// Valid/ready stream bundle used on both sides of pipe_stage_reg.
//   valid : producer presents a payload
//   ready : consumer can take it; a transfer happens when valid && ready
//   data  : payload, DATA_W bits
// The master modport is the producer side and the slave modport is the consumer side.
interface pipe_stage_reg_if #(
    parameter int DATA_W = 64
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register with a valid/ready handshake.
// It is a drop-in replacement for the fixed if_id/id_ex/ex_mem/mem_wb latches.
//
// Ports:
//   sys_clk    : clock; all state updates on the rising edge
//   sys_rst    : asynchronous active-low reset
//   up         : upstream stream (slave side)
//                - in_valid/in_data are up.valid/up.data
//                - in_ready is up.ready
//   dn         : downstream stream (master side)
//                - out_valid/out_data are dn.valid/dn.data
//                - out_ready is dn.ready
//   flush      : synchronous kill of every held entry (branch/trap redirect)
//   occupancy  : number of held entries, 0..2 (never above 1 when SKID=0)
//   stall_cnt  : saturating count of cycles with out_valid && !out_ready
//   stall_clr  : synchronous clear of stall_cnt, wins over an increment
//
// When SKID=1 a second (skid) entry absorbs the payload that arrives while
// downstream stalls. This lets in_ready come straight from a flop instead of
// from out_ready. When SKID=0 the stage holds a single entry, and in_ready is
// the usual combinational !out_valid || out_ready.
module pipe_stage_reg #(
    parameter int                DATA_W   = 64,
    parameter int                SKID     = 1,
    parameter int                CNT_W    = 16,
    parameter logic [DATA_W-1:0] RST_DATA = '0
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    pipe_stage_reg_if.slave  up,
    pipe_stage_reg_if.master dn,
    input  logic             flush,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt,
    input  logic             stall_clr
);

    // The encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_e;

    occ_e              state_p0;
    logic [DATA_W-1:0] head_p0;
    logic [DATA_W-1:0] skid_p1;
    logic              ready_q;
    logic              accept;
    logic              drain;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign accept    = up.valid && up.ready;
    assign drain     = dn.valid && dn.ready;
    assign dn.valid  = (state_p0 != EMPTY);
    assign dn.data   = head_p0;
    assign occupancy = state_p0;

    // With a skid entry, ready is the registered "next occupancy != 2".
    // Without one, ready has to look through to downstream in the same cycle.
    assign up.ready = (SKID != 0) ? ready_q : (!dn.valid || dn.ready);

    // Stage register: head feeds downstream, skid holds the overflow entry
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state_p0  <= EMPTY;
            ready_q   <= 1'b1;
            head_p0   <= RST_DATA;
            skid_p1   <= RST_DATA;
            stall_cnt <= '0;
        end else begin
            // A flush cycle is a redirect, not a downstream stall.
            if (stall_clr) begin
                stall_cnt <= '0;
            end else if (dn.valid && !dn.ready && !flush) begin
                stall_cnt <= sat_inc(stall_cnt);
            end

            // Flush discards held entries and any payload offered this cycle.
            // The data registers keep their stale contents because out_valid
            // already masks them.
            if (flush) begin
                state_p0 <= EMPTY;
                ready_q  <= 1'b1;
            end else begin
                unique case (state_p0)
                    EMPTY: begin
                        if (accept) begin
                            head_p0  <= up.data;
                            state_p0 <= ONE;
                        end
                    end
                    ONE: begin
                        if (accept && drain) begin
                            head_p0 <= up.data;
                        end else if (accept && (SKID != 0)) begin
                            skid_p1  <= up.data;
                            state_p0 <= TWO;
                            ready_q  <= 1'b0;
                        end else if (drain) begin
                            state_p0 <= EMPTY;
                        end
                    end
                    TWO: begin
                        // ready_q is low here, so no accept can coincide.
                        if (drain) begin
                            head_p0  <= skid_p1;
                            state_p0 <= ONE;
                            ready_q  <= 1'b1;
                        end
                    end
                    default: begin
                        state_p0 <= EMPTY;
                        ready_q  <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised inter-stage pipeline register that replaces the fixed if_id/id_ex/ex_mem/mem_wb latches, which have a single shared valid input. It carries a DATA_W-bit payload between two pipeline stages using a valid/ready handshake. An optional 2-entry skid buffer keeps in_ready registered, so the ready path is timing-clean. It also supports a flush for branch redirects and a saturating stall-cycle counter for performance monitoring.

Parameters:
DATA_W, 64, payload width in bits (the packed stage bundle).
SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready.
CNT_W, 16, width of the stall performance counter.
RST_DATA, 0, value loaded into the data registers on reset.

Ports:
sys_clk  in  1  clock; all state updates on the rising edge.
sys_rst  in  1  reset; asynchronous, active-low.
in_valid  in  1  upstream stage presents a payload.
in_ready  out  1  this stage can accept; a transfer happens when in_valid && in_ready.
in_data  in  DATA_W  upstream payload.
out_valid  out  1  a payload is held for downstream.
out_ready  in  1  downstream accepts; a transfer happens when out_valid && out_ready.
out_data  out  DATA_W  held payload, always taken from the head entry.
flush  in  1  synchronous kill of all held entries (branch or trap redirect).
occupancy  out  2  number of held entries (0..2; never exceeds 1 when SKID=0).
stall_cnt  out  CNT_W  cycles with out_valid && !out_ready; saturates at all-ones.
stall_clr  in  1  synchronous clear of stall_cnt.

Behaviour:
- Reset (sys_rst=0, asynchronous):
  - occupancy=0, out_valid=0, stall_cnt=0.
  - in_ready=1 when SKID=1.
  - Head and skid data registers load RST_DATA.
- Storage: head register (drives out_data) and skid register (SKID=1 only).
- SKID=1 state machine on occupancy:
  - EMPTY: accept -> ONE, in_data written to head.
  - ONE, accept without drain -> TWO, in_data written to skid.
  - ONE, drain without accept -> EMPTY.
  - ONE, accept and drain -> ONE, head <= in_data.
  - TWO, drain -> ONE, head <= skid.
  - TWO, no drain -> stays TWO.
  - in_ready is a flop, equal to (next occupancy != 2). It is never a combinational function of out_ready.
- SKID=0: single entry.
  - in_ready = !out_valid || out_ready, combinational.
  - Accept and drain in the same cycle -> head <= in_data, out_valid stays 1.
- out_valid = (occupancy != 0).
- out_data is stable while out_valid && !out_ready. Payload order is strict FIFO.
- Latency: a payload accepted in cycle N appears on out_data in cycle N+1 when the stage was empty.
- Flush:
  - Next cycle: occupancy=0, out_valid=0, in_ready=1.
  - Overrides a simultaneous accept; the incoming payload is dropped.
  - A simultaneous drain still counts as transferred downstream.
  - Data registers are not cleared.
- stall_cnt:
  - Increments when out_valid && !out_ready && !flush.
  - Holds at 2^CNT_W-1 once saturated.
  - stall_clr has priority over increment.
- Data and handshake inputs are not sampled during reset. Deasserting reset mid-transaction restarts the stage from EMPTY.

Test Plan:
- Reset then stream: assert reset mid-transfer, release, drive 0x11,0x22,0x33 with out_ready=1 -> out_data 0x11,0x22,0x33 on consecutive cycles; in_ready=1 throughout; occupancy never exceeds 1.
- Backpressure with SKID=1: out_ready=0, push 0xA,0xB -> occupancy=2; in_ready=0 from the following cycle; 0xC is held upstream; after out_ready=1, outputs are 0xA,0xB,0xC in order.
- Flush with accept: occupancy=2, then flush=1 with in_valid=1 and in_data=0xDEAD -> next cycle occupancy=0, out_valid=0, in_ready=1; 0xDEAD never appears on out_data.
- SKID=0 pass-through: out_valid=1, out_ready=1, in_valid=1 with in_data=0x55 -> in_ready=1 the same cycle; out_data=0x55 next cycle; occupancy stays 1.
- Stall counter with CNT_W=4: hold out_valid with out_ready=0 for 20 cycles -> stall_cnt=15 (saturated); stall_clr=1 -> 0 next cycle; no increment in the clear cycle.
- Random valid/ready over 10k cycles with a scoreboard -> no loss, no duplication, order preserved, out_data never changes while stalled.
